// File: rtl/bin_to_bcd_converter.sv
// 14-bit binary to 4-digit BCD converter using sequential double-dabble.
// Digits and overflow change only when a finished result is committed, so a display never sees partial values.
`timescale 1ns/1ps
module bin_to_bcd_converter #(
  parameter bit BLANK_ZEROS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_CONVERT = 2'd1;
  localparam logic [1:0]  S_COMMIT  = 2'd2;
  localparam logic [3:0]  LAST_ITER = 4'd13;
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  logic [1:0]  r_state;
  logic [3:0]  r_iter;
  logic [29:0] r_shift;     // {thousands, hundreds, tens, ones, binary operand}
  logic        r_ovf_cap;
  logic        r_overflow;
  logic [15:0] r_digits;

  logic [29:0] w_adj;
  logic [29:0] w_next;
  logic [15:0] w_bcd;
  logic [15:0] w_disp;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < 4; k++) begin
      if (r_shift[14 + 4*k +: 4] >= 4'd5) begin
        w_adj[14 + 4*k +: 4] = r_shift[14 + 4*k +: 4] + 4'd3;
      end
    end
    w_next = {w_adj[28:0], 1'b0};
  end

  assign w_bcd = w_next[29:14];

  // Leading-zero blanking scans from the thousands digit down; the ones digit is always shown.
  always_comb begin
    w_disp = w_bcd;
    if (r_ovf_cap) begin
      w_disp = 16'hEEEE;
    end else if (BLANK_ZEROS) begin
      if (w_bcd[15:12] == 4'd0) begin
        w_disp[15:12] = 4'hF;
        if (w_bcd[11:8] == 4'd0) begin
          w_disp[11:8] = 4'hF;
          if (w_bcd[7:4] == 4'd0) begin
            w_disp[7:4] = 4'hF;
          end
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_iter     <= 4'd0;
      r_shift    <= 30'd0;
      r_ovf_cap  <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= {16'd0, value};
            r_ovf_cap <= (value > MAX_VALUE);
            r_iter    <= 4'd0;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_shift <= w_next;
          r_iter  <= r_iter + 4'd1;
          // The final iteration's result is committed on the same edge it is computed.
          if (r_iter == LAST_ITER) begin
            r_state    <= S_COMMIT;
            r_digits   <= w_disp;
            r_overflow <= r_ovf_cap;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_CONVERT);
  assign done     = (r_state == S_COMMIT);
  assign overflow = r_overflow;
  assign digit3   = r_digits[15:12];
  assign digit2   = r_digits[11:8];
  assign digit1   = r_digits[7:4];
  assign digit0   = r_digits[3:0];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: one plain and one blanking instance share the same stimulus.
`timescale 1ns/1ps
module tb_bin_to_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] value;

  logic        busy0, done0, overflow0;
  logic [3:0]  d0_0, d1_0, d2_0, d3_0;
  logic        busy1, done1, overflow1;
  logic [3:0]  d0_1, d1_1, d2_1, d3_1;
  logic [15:0] dig0, dig1;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_converter #(.BLANK_ZEROS(1'b0)) u_dut_plain (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy0), .done(done0), .overflow(overflow0),
    .digit0(d0_0), .digit1(d1_0), .digit2(d2_0), .digit3(d3_0)
  );

  bin_to_bcd_converter #(.BLANK_ZEROS(1'b1)) u_dut_blank (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy1), .done(done1), .overflow(overflow1),
    .digit0(d0_1), .digit1(d1_1), .digit2(d2_1), .digit3(d3_1)
  );

  assign dig0 = {d3_0, d2_0, d1_0, d0_0};
  assign dig1 = {d3_1, d2_1, d1_1, d0_1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_plain(input int v);
    logic [15:0] d;
    d[15:12] = 4'(v / 1000);
    d[11:8]  = 4'((v / 100) % 10);
    d[7:4]   = 4'((v / 10) % 10);
    d[3:0]   = 4'(v % 10);
    return d;
  endfunction

  function automatic logic [15:0] ref_blank(input int v);
    logic [15:0] d;
    d = ref_plain(v);
    if (v < 1000) d[15:12] = 4'hF;
    if (v < 100)  d[11:8]  = 4'hF;
    if (v < 10)   d[7:4]   = 4'hF;
    return d;
  endfunction

  function automatic logic [13:0] v4_val(input int k);
    return 14'((k * 613 + 17) % 10000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion, then waits (bounded) until done; leaves the DUT in COMMIT.
  task automatic convert(input string tag, input logic [13:0] v);
    int n;
    int busy_cnt;
    value = v;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done0 && n < 40) begin
      if (busy0) busy_cnt++;
      step();
      n++;
    end
    check({tag, "_latency"}, n, 14);
    check({tag, "_busy_cycles"}, busy_cnt, 14);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    value = 14'd0;
    #12;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ovf", overflow0, 0);
    check("rst_digits", dig0, 16'h0000);
    check("rst_digits_blank", dig1, 16'h0000);
    check("rst_busy_blank", busy1, 0);
    rst_n = 1'b1;
    step();

    // V1
    convert("v1", 14'd1234);
    check("v1_digits", dig0, 16'h1234);
    check("v1_ovf", overflow0, 0);
    check("v1_digits_blank", dig1, 16'h1234);
    step();
    check("v1_done_pulse", done0, 0);
    check("v1_idle_busy", busy0, 0);
    value = 14'd55;
    repeat (3) step();
    check("v1_hold", dig0, 16'h1234);

    // V2
    convert("v2a", 14'd10000);
    check("v2a_ovf", overflow0, 1);
    check("v2a_digits", dig0, 16'hEEEE);
    check("v2a_ovf_blank", overflow1, 1);
    check("v2a_digits_blank", dig1, 16'hEEEE);
    step();
    convert("v2b", 14'd9999);
    check("v2b_ovf", overflow0, 0);
    check("v2b_digits", dig0, 16'h9999);
    step();

    // V3
    convert("v3_0", 14'd0);
    check("v3_0_blank", dig1, 16'hFFF0);
    check("v3_0_plain", dig0, 16'h0000);
    check("v3_0_done_blank", done1, 1);
    step();
    convert("v3_7", 14'd7);
    check("v3_7_blank", dig1, 16'hFFF7);
    step();
    convert("v3_305", 14'd305);
    check("v3_305_blank", dig1, 16'hF305);
    check("v3_305_plain", dig0, 16'h0305);
    step();

    // V4: start held high, value changes every cycle
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      value = v4_val(k);
      step();
      if (done0) begin
        ndone++;
        check("v4_phase", (k - 14) % 16, 0);
        check("v4_digits", dig0, ref_plain(int'(v4_val(k - 14))));
      end
    end
    start = 1'b0;
    check("v4_count", ndone, 4);
    step();

    // V5: reset in the middle of CONVERT
    value = 14'd4321;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("v5_busy", busy0, 0);
    check("v5_done", done0, 0);
    check("v5_digits", dig0, 16'h0000);
    check("v5_digits_blank", dig1, 16'h0000);
    check("v5_ovf", overflow0, 0);
    step();
    step();
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      step();
      if (done0) ndone++;
    end
    check("v5_no_done", ndone, 0);
    convert("v5_after", 14'd4321);
    check("v5_after_digits", dig0, 16'h4321);
    step();

    // V6: sweep against the arithmetic reference
    for (int v = 0; v < 10000; v += 5) begin
      convert("v6", 14'(v));
      check("v6_digits", dig0, ref_plain(v));
      check("v6_ovf", overflow0, 0);
      step();
    end
    convert("v6_max", 14'd9999);
    check("v6_max_digits", dig0, 16'h9999);
    check("v6_max_blank", dig1, 16'h9999);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
